multicycle_control_fsm: RTL

Main control sequencer for the multicycle MIPS datapath. Steps each instruction through fetch, decode, execute, memory and write-back states, and drives every datapath mux select and write enable: PC, IR, register file, memory, ALU operand/op selects and the shift-amount select. Sits beside the datapath top, fed by the opcode/funct fields of the instruction register.

---
 rtl/mips_ctrl_pkg.sv | 70 +++++++
 rtl/multicycle_control_fsm_decoder.sv | 74 +++++++
 rtl/multicycle_control_fsm.sv | 92 +++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control sequencer:
// state encoding, opcode/funct constants and datapath select encodings.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADR   = 4'd3,
        S_MEM_RD    = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WR    = 4'd6,
        S_R_EXEC    = 4'd7,
        S_R_WB      = 4'd8,
        S_BRANCH    = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_JUMP      = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FUNCT_SLL = 6'h00;
    localparam logic [5:0] FUNCT_SRL = 6'h02;

    localparam logic [1:0] ALUB_B       = 2'b00;
    localparam logic [1:0] ALUB_FOUR    = 2'b01;
    localparam logic [1:0] ALUB_IMM     = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Full set of datapath controls produced for one state.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ior_sel;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       shamt_sel;
        logic       instr_done;
        logic       illegal_op;
    } ctrl_word_t;

    // True for the opcodes this sequencer knows how to execute.
    function automatic logic is_supported_opcode(input logic [5:0] opcode);
        return (opcode == OP_RTYPE) || (opcode == OP_LW) || (opcode == OP_SW) ||
               (opcode == OP_BEQ) || (opcode == OP_ADDI) || (opcode == OP_J);
    endfunction

endpackage

// File: rtl/multicycle_control_fsm_decoder.sv
// Combinational control-word decode: registered state (plus funct for the
// shift-amount select and opcode for the illegal-op flag) to datapath controls.
module mc_ctrl_decoder
    import mips_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output ctrl_word_t ctrl
);

    // Start from all-zero controls and raise only what each state needs.
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
                ctrl.alu_src_b = ALUB_FOUR;
            end
            S_DECODE: begin
                ctrl.alu_src_b  = ALUB_IMM_SH2;
                ctrl.illegal_op = ~is_supported_opcode(opcode);
            end
            S_MEM_ADR, S_ADDI_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUB_IMM;
            end
            S_MEM_RD: begin
                ctrl.ior_sel  = 1'b1;
                ctrl.mem_read = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.ior_sel    = 1'b1;
                ctrl.mem_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALUOP_FUNCT;
                ctrl.shamt_sel = (funct == FUNCT_SLL) || (funct == FUNCT_SRL);
            end
            S_R_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.instr_done    = 1'b1;
            end
            S_ADDI_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PCSRC_JUMP;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS control sequencer: state register and next-state logic,
// with the per-state control word coming from mc_ctrl_decoder.
module multicycle_control_fsm
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] in_opcode_6,
    input  logic [5:0] in_funct_6,
    output logic       out_pc_write,
    output logic       out_pc_write_cond,
    output logic       out_ior_sel,
    output logic       out_mem_read,
    output logic       out_mem_write,
    output logic       out_ir_write,
    output logic       out_reg_dst,
    output logic       out_mem_to_reg,
    output logic       out_reg_write,
    output logic       out_alu_src_a,
    output logic [1:0] out_alu_src_b,
    output logic [1:0] out_alu_op,
    output logic [1:0] out_pc_source,
    output logic       out_shamt_sel,
    output logic       out_instr_done,
    output logic       out_illegal_op,
    output logic [3:0] out_state_4
);

    state_t     state;
    state_t     next_state;
    ctrl_word_t ctrl;

    // State register; reset is active-low and drops straight to IDLE,
    // which also forces every control output to zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state selection; anything unexpected recovers through FETCH.
    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_IDLE:   next_state = S_FETCH;
            S_FETCH:  next_state = S_DECODE;
            S_DECODE: begin
                case (in_opcode_6)
                    OP_LW, OP_SW: next_state = S_MEM_ADR;
                    OP_RTYPE:     next_state = S_R_EXEC;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_ADDI:      next_state = S_ADDI_EXEC;
                    OP_J:         next_state = S_JUMP;
                    default:      next_state = S_FETCH;
                endcase
            end
            S_MEM_ADR:   next_state = (in_opcode_6 == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:    next_state = S_MEM_WB;
            S_R_EXEC:    next_state = S_R_WB;
            S_ADDI_EXEC: next_state = S_ADDI_WB;
            default:     next_state = S_FETCH;
        endcase
    end

    mc_ctrl_decoder u_decoder (
        .state  (state),
        .opcode (in_opcode_6),
        .funct  (in_funct_6),
        .ctrl   (ctrl)
    );

    assign out_pc_write      = ctrl.pc_write;
    assign out_pc_write_cond = ctrl.pc_write_cond;
    assign out_ior_sel       = ctrl.ior_sel;
    assign out_mem_read      = ctrl.mem_read;
    assign out_mem_write     = ctrl.mem_write;
    assign out_ir_write      = ctrl.ir_write;
    assign out_reg_dst       = ctrl.reg_dst;
    assign out_mem_to_reg    = ctrl.mem_to_reg;
    assign out_reg_write     = ctrl.reg_write;
    assign out_alu_src_a     = ctrl.alu_src_a;
    assign out_alu_src_b     = ctrl.alu_src_b;
    assign out_alu_op        = ctrl.alu_op;
    assign out_pc_source     = ctrl.pc_source;
    assign out_shamt_sel     = ctrl.shamt_sel;
    assign out_instr_done    = ctrl.instr_done;
    assign out_illegal_op    = ctrl.illegal_op;
    assign out_state_4       = state;

endmodule
